// File: rtl/posit_decoder_pipe_pkg.sv
// Shared widths and the decoded-field record for the default 32-bit, es=3 posit format.
package posit_decoder_pipe_pkg;

    localparam int POSIT_W  = 32;
    localparam int POSIT_ES = 3;
    localparam int SW       = $clog2(POSIT_W) + POSIT_ES + 1;
    localparam int MW       = POSIT_W - POSIT_ES - 1;

    typedef struct packed {
        logic                 sign;
        logic signed [SW-1:0] scale;
        logic [MW-1:0]        mant;
        logic                 zero;
        logic                 nar;
    } posit_fields_t;

endpackage

// File: rtl/posit_regime_count.sv
// Regime decoder: reports the leading bit of the posit body and how many copies of it lead.
module posit_regime_count
    import posit_decoder_pipe_pkg::*;
#(
    parameter int  WIDTH = POSIT_W,
    localparam int LW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-2:0] body,
    output logic             run_bit,
    output logic [LW-1:0]    run_len
);

    logic running_s;

    // Walk down from the MSB; the first bit differing from the leading one terminates the run.
    always_comb begin
        run_bit   = body[WIDTH-2];
        run_len   = '0;
        running_s = 1'b1;
        for (int i = WIDTH - 2; i >= 0; i--) begin
            if (running_s && (body[i] == body[WIDTH-2])) begin
                run_len = run_len + LW'(1);
            end else begin
                running_s = 1'b0;
            end
        end
    end

endmodule

// File: rtl/two_comp.sv
// Two's-complement negation of a WIDTH-bit word.
module two_comp #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    assign y = ~a + {{(WIDTH-1){1'b0}}, 1'b1};

endmodule

// File: rtl/posit_decoder_pipe.sv
// Three-stage posit unpacker: magnitude/special detect, regime count, field extraction.
// All stages stall together when the output holds an unaccepted result.
module posit_decoder_pipe
    import posit_decoder_pipe_pkg::*;
#(
    parameter int  WIDTH   = POSIT_W,
    parameter int  EN      = POSIT_ES,
    localparam int SCALE_W = $clog2(WIDTH) + EN + 1,
    localparam int MANT_W  = WIDTH - EN - 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_posit,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_sign,
    output logic signed [SCALE_W-1:0] out_scale,
    output logic [MANT_W-1:0]         out_mant,
    output logic                      out_zero,
    output logic                      out_nar
);

    localparam int LW = $clog2(WIDTH);

    logic                      advance_s;
    logic [WIDTH-1:0]          neg_s;
    logic [WIDTH-2:0]          body_s;
    logic                      zero_s;
    logic                      nar_s;

    logic                      s1_valid_r;
    logic                      s1_sign_r;
    logic [WIDTH-2:0]          s1_body_r;
    logic                      s1_zero_r;
    logic                      s1_nar_r;

    logic                      run_bit_s;
    logic [LW-1:0]             run_len_s;

    logic                      s2_valid_r;
    logic                      s2_sign_r;
    logic [WIDTH-3:0]          s2_body_r;
    logic                      s2_zero_r;
    logic                      s2_nar_r;
    logic                      s2_run_r;
    logic [LW-1:0]             s2_len_r;

    logic [WIDTH-3:0]          shifted_s;
    logic [EN-1:0]             exp_s;
    logic [MANT_W-2:0]         frac_s;
    logic signed [SCALE_W-1:0] len_ext_s;
    logic signed [SCALE_W-1:0] k_s;
    logic signed [SCALE_W-1:0] scale_s;
    logic                      nx_sign_s;
    logic signed [SCALE_W-1:0] nx_scale_s;
    logic [MANT_W-1:0]         nx_mant_s;

    logic                      out_valid_r;
    logic                      out_sign_r;
    logic signed [SCALE_W-1:0] out_scale_r;
    logic [MANT_W-1:0]         out_mant_r;
    logic                      out_zero_r;
    logic                      out_nar_r;

    assign advance_s = !out_valid_r || out_ready;
    assign in_ready  = advance_s;

    two_comp #(.WIDTH(WIDTH)) u_neg (
        .a (in_posit),
        .y (neg_s)
    );

    // Stage-1 combinational: magnitude body and special-value detection.
    // Negating a negative posit leaves the MSB set only for the NaR pattern.
    always_comb begin
        zero_s = (in_posit == '0);
        nar_s  = in_posit[WIDTH-1] & neg_s[WIDTH-1];
        if (in_posit[WIDTH-1]) begin
            body_s = neg_s[WIDTH-2:0];
        end else begin
            body_s = in_posit[WIDTH-2:0];
        end
    end

    // Stage-1 registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_r <= 1'b0;
            s1_sign_r  <= 1'b0;
            s1_body_r  <= '0;
            s1_zero_r  <= 1'b0;
            s1_nar_r   <= 1'b0;
        end else if (advance_s) begin
            s1_valid_r <= in_valid;
            s1_sign_r  <= in_posit[WIDTH-1];
            s1_body_r  <= body_s;
            s1_zero_r  <= zero_s;
            s1_nar_r   <= nar_s;
        end
    end

    posit_regime_count #(.WIDTH(WIDTH)) u_regime (
        .body    (s1_body_r),
        .run_bit (run_bit_s),
        .run_len (run_len_s)
    );

    // Stage-2 registers; the top body bit is always part of the run and is not kept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid_r <= 1'b0;
            s2_sign_r  <= 1'b0;
            s2_body_r  <= '0;
            s2_zero_r  <= 1'b0;
            s2_nar_r   <= 1'b0;
            s2_run_r   <= 1'b0;
            s2_len_r   <= '0;
        end else if (advance_s) begin
            s2_valid_r <= s1_valid_r;
            s2_sign_r  <= s1_sign_r;
            s2_body_r  <= s1_body_r[WIDTH-3:0];
            s2_zero_r  <= s1_zero_r;
            s2_nar_r   <= s1_nar_r;
            s2_run_r   <= run_bit_s;
            s2_len_r   <= run_len_s;
        end
    end

    // Stage-3 combinational: shifting by the run length drops the rest of the run and the
    // terminator, leaving exponent then fraction left-aligned; invalid/special results read 0.
    always_comb begin
        shifted_s = s2_body_r << s2_len_r;
        exp_s     = shifted_s[WIDTH-3 -: EN];
        frac_s    = shifted_s[WIDTH-3-EN:0];
        len_ext_s = $signed({{(SCALE_W-LW){1'b0}}, s2_len_r});
        if (s2_run_r) begin
            k_s = len_ext_s - SCALE_W'(1);
        end else begin
            k_s = -len_ext_s;
        end
        scale_s = (k_s <<< EN) + $signed({{(SCALE_W-EN){1'b0}}, exp_s});
        if (s2_valid_r && !s2_zero_r && !s2_nar_r) begin
            nx_sign_s  = s2_sign_r;
            nx_scale_s = scale_s;
            nx_mant_s  = {1'b1, frac_s};
        end else begin
            nx_sign_s  = 1'b0;
            nx_scale_s = '0;
            nx_mant_s  = '0;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_r <= 1'b0;
            out_sign_r  <= 1'b0;
            out_scale_r <= '0;
            out_mant_r  <= '0;
            out_zero_r  <= 1'b0;
            out_nar_r   <= 1'b0;
        end else if (advance_s) begin
            out_valid_r <= s2_valid_r;
            out_sign_r  <= nx_sign_s;
            out_scale_r <= nx_scale_s;
            out_mant_r  <= nx_mant_s;
            out_zero_r  <= s2_valid_r & s2_zero_r;
            out_nar_r   <= s2_valid_r & s2_nar_r;
        end
    end

    assign out_valid = out_valid_r;
    assign out_sign  = out_sign_r;
    assign out_scale = out_scale_r;
    assign out_mant  = out_mant_r;
    assign out_zero  = out_zero_r;
    assign out_nar   = out_nar_r;

endmodule

// File: tb/tb_posit_decoder_pipe.sv
// Directed and randomised bench for posit_decoder_pipe (default 32/3 configuration).
`timescale 1ns/1ps
module tb_posit_decoder_pipe;
    import posit_decoder_pipe_pkg::*;

    typedef struct packed {
        logic [31:0]   p;
        posit_fields_t f;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [31:0]          in_posit = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic                 out_sign;
    logic signed [SW-1:0] out_scale;
    logic [MW-1:0]        out_mant;
    logic                 out_zero;
    logic                 out_nar;
    posit_fields_t        out_f;

    int tests = 0;
    int fails = 0;
    vec_t vecs [13];
    logic [31:0] blist [8];

    always #5 clk = ~clk;

    assign out_f = {out_sign, out_scale, out_mant, out_zero, out_nar};

    posit_decoder_pipe #(.WIDTH(32), .EN(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_posit  (in_posit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_scale (out_scale),
        .out_mant  (out_mant),
        .out_zero  (out_zero),
        .out_nar   (out_nar)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic posit_fields_t fl(input logic s, input int sc, input logic [MW-1:0] m,
                                         input logic z, input logic n);
        posit_fields_t f;
        f.sign  = s;
        f.scale = SW'(sc);
        f.mant  = m;
        f.zero  = z;
        f.nar   = n;
        return f;
    endfunction

    // Reference decode: walk the bits of the magnitude one at a time.
    function automatic posit_fields_t model(input logic [31:0] p);
        posit_fields_t f;
        logic [31:0]   v;
        logic          r;
        int            i;
        int            m;
        int            k;
        int            e;
        f = '0;
        if (p == 32'h0000_0000) begin
            f.zero = 1'b1;
            return f;
        end
        if (p == 32'h8000_0000) begin
            f.nar = 1'b1;
            return f;
        end
        f.sign = p[31];
        v = p[31] ? (~p + 32'd1) : p;
        r = v[30];
        m = 0;
        i = 30;
        while (i >= 0) begin
            if (v[i] != r) break;
            m++;
            i--;
        end
        i--;
        k = r ? m - 1 : -m;
        e = 0;
        for (int j = 0; j < POSIT_ES; j++) begin
            e = e * 2;
            if (i >= 0) e = e + int'(v[i]);
            i--;
        end
        f.mant[MW-1] = 1'b1;
        for (int pos = MW - 2; pos >= 0; pos--) begin
            if (i >= 0) f.mant[pos] = v[i];
            i--;
        end
        f.scale = SW'(k * (1 << POSIT_ES) + e);
        return f;
    endfunction

    function automatic logic [31:0] rand_posit();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(15))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return r >> $urandom_range(31);
            3:       return ~(r >> $urandom_range(31));
            default: return r;
        endcase
    endfunction

    task automatic send_single(input logic [31:0] p, input posit_fields_t exp, input string name);
        int lat;
        @(negedge clk);
        out_ready = 1'b1;
        chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
        in_posit = p;
        in_valid = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 10);
        chk({name, "_latency"}, 64'(lat), 64'd3);
        chk({name, "_fields"}, 64'(out_f), 64'(exp));
    endtask

    task automatic run_stream(input int n, input int vpct, input int rpct, input bit use_list,
                              input string name);
        posit_fields_t expq [$];
        posit_fields_t held;
        posit_fields_t want;
        int  sent = 0;
        int  recv = 0;
        int  cyc = 0;
        bit  stalled = 1'b0;
        bit  acc = 1'b0;
        in_valid = 1'b0;
        while ((sent < n || in_valid || expq.size() > 0) && cyc < n * 20 + 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (acc) begin
                in_valid = 1'b0;
                acc = 1'b0;
            end
            if (!in_valid && sent < n && $urandom_range(99) < vpct) begin
                in_valid = 1'b1;
                in_posit = use_list ? blist[sent] : rand_posit();
            end
            out_ready = ($urandom_range(99) < rpct);
            @(negedge clk);
            chk({name, "_ready_rule"}, 64'(in_ready), 64'(!(out_valid && !out_ready)));
            if (stalled) chk({name, "_stable"}, 64'({out_valid, out_f}), 64'({1'b1, held}));
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL %s_extra: got output %h with nothing expected", name, out_f);
                end else begin
                    want = expq.pop_front();
                    chk({name, "_data"}, 64'(out_f), 64'(want));
                end
                recv++;
            end
            stalled = out_valid && !out_ready;
            held = out_f;
            if (in_valid && in_ready) begin
                expq.push_back(model(in_posit));
                sent++;
                acc = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({name, "_count"}, 64'(recv), 64'(n));
    endtask

    initial begin
        vecs[0]  = '{32'h4000_0000, fl(1'b0,    0, 28'h800_0000, 1'b0, 1'b0)};
        vecs[1]  = '{32'h4800_0000, fl(1'b0,    2, 28'h800_0000, 1'b0, 1'b0)};
        vecs[2]  = '{32'h4000_0001, fl(1'b0,    0, 28'h800_0002, 1'b0, 1'b0)};
        vecs[3]  = '{32'hC000_0000, fl(1'b1,    0, 28'h800_0000, 1'b0, 1'b0)};
        vecs[4]  = '{32'h7FFF_FFFF, fl(1'b0,  240, 28'h800_0000, 1'b0, 1'b0)};
        vecs[5]  = '{32'h0000_0001, fl(1'b0, -240, 28'h800_0000, 1'b0, 1'b0)};
        vecs[6]  = '{32'h8000_0001, fl(1'b1,  240, 28'h800_0000, 1'b0, 1'b0)};
        vecs[7]  = '{32'h0000_0000, fl(1'b0,    0, 28'h000_0000, 1'b1, 1'b0)};
        vecs[8]  = '{32'h8000_0000, fl(1'b0,    0, 28'h000_0000, 1'b0, 1'b1)};
        vecs[9]  = '{32'h3FFF_FFFF, fl(1'b0,   -1, 28'hFFF_FFFE, 1'b0, 1'b0)};
        vecs[10] = '{32'h6000_0000, fl(1'b0,    8, 28'h800_0000, 1'b0, 1'b0)};
        vecs[11] = '{32'hFFFF_FFFF, fl(1'b1, -240, 28'h800_0000, 1'b0, 1'b0)};
        vecs[12] = '{32'h4080_0000, fl(1'b0,    0, 28'h900_0000, 1'b0, 1'b0)};
        blist = '{32'h4000_0000, 32'h0000_0000, 32'hC000_0000, 32'h8000_0000,
                  32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h4080_0000, 32'h0000_0001};

        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({out_valid, out_f}), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;

        for (int v = 0; v < 13; v++) begin
            send_single(vecs[v].p, vecs[v].f, $sformatf("vec%0d_%h", v, vecs[v].p));
        end

        // zero, NaR and 1.0 on consecutive cycles must leave on consecutive cycles
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_posit = 32'h0000_0000;
        @(posedge clk); #1; in_posit = 32'h8000_0000;
        @(posedge clk); #1; in_posit = 32'h4000_0000;
        @(posedge clk); #1; in_valid = 1'b0;
        chk("b2b_zero", 64'({out_valid, out_f}), 64'({1'b1, vecs[7].f}));
        @(posedge clk); #1;
        chk("b2b_nar", 64'({out_valid, out_f}), 64'({1'b1, vecs[8].f}));
        @(posedge clk); #1;
        chk("b2b_one", 64'({out_valid, out_f}), 64'({1'b1, vecs[0].f}));
        @(posedge clk); #1;
        chk("b2b_drained", 64'(out_valid), 64'd0);

        run_stream(8, 100, 50, 1'b1, "bp");

        // reset with three items in flight
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_posit = 32'h4800_0000;
        @(posedge clk); #1; in_posit = 32'h3FFF_FFFF;
        @(posedge clk); #1; in_posit = 32'h7FFF_FFFF;
        @(posedge clk); #1; in_valid = 1'b0;
        chk("inflight_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst_outputs", 64'({out_valid, out_f}), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk($sformatf("postrst_idle%0d", c), 64'(out_valid), 64'd0);
        end
        send_single(32'h4000_0000, vecs[0].f, "postrst_one");

        run_stream(10000, 70, 70, 1'b0, "rand");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
